// File: rtl/rram_instr_fifo_if.sv
// rram_instr_fifo_if: push/pop handshake bundle for the instruction FIFO.
//   master : command producer / controller side (drives push_n, din, pop_n)
//   slave  : FIFO side (drives full, almost_full, empty, dout, count)
//   With RRAM_INSTR_FIFO_ERR_EN defined, the sticky overflow/underflow
//   flags are also carried.
interface rram_instr_fifo_if #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             push_n;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             almost_full;
    logic             pop_n;
    logic             empty;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
`ifdef RRAM_INSTR_FIFO_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    modport master (
        output push_n, din, pop_n,
        input  full, almost_full, empty, dout, count
`ifdef RRAM_INSTR_FIFO_ERR_EN
      , input  overflow, underflow
`endif
    );

    modport slave (
        input  push_n, din, pop_n,
        output full, almost_full, empty, dout, count
`ifdef RRAM_INSTR_FIFO_ERR_EN
      , output overflow, underflow
`endif
    );
endinterface

// File: rtl/rram_instr_fifo.sv
// rram_instr_fifo: first-word-fall-through instruction FIFO feeding
// rram_controller_fsm. The head entry is always visible on dout while empty
// is low; an active-low pop retires it.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (clears pointers, count, array)
//   bus    : rram_instr_fifo_if.slave (push_n, din, full, almost_full,
//            pop_n, empty, dout, count [, overflow, underflow])
// Optional macro RRAM_INSTR_FIFO_ERR_EN adds sticky overflow/underflow flags.
module rram_instr_fifo #(
    parameter int unsigned WIDTH    = 20,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    rram_instr_fifo_if.slave    bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             pop_acc_c;
    logic             push_acc_c;

    // Accept decisions from pre-edge state; a pop frees the slot a full push needs.
    always_comb begin
        pop_acc_c  = 1'b0;
        push_acc_c = 1'b0;
        pop_acc_c  = !bus.pop_n && (cnt != '0);
        push_acc_c = !bus.push_n && ((cnt != CW'(DEPTH)) || pop_acc_c);
    end

    // Storage array, cleared on reset so dout reads 0 while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_acc_c) begin
            mem[wp] <= bus.din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_acc_c) wp <= wp + PW'(1);
            if (pop_acc_c)  rp <= rp + PW'(1);
            cnt <= cnt + CW'(push_acc_c) - CW'(pop_acc_c);
        end
    end

`ifdef RRAM_INSTR_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (!bus.push_n && !push_acc_c) ovf_q <= 1'b1;
            if (!bus.pop_n && (cnt == '0))  udf_q <= 1'b1;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`endif

    // Status decoded from the registered count only.
    assign bus.dout        = mem[rp];
    assign bus.count       = cnt;
    assign bus.empty       = (cnt == '0);
    assign bus.full        = (cnt == CW'(DEPTH));
    assign bus.almost_full = (cnt >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_rram_instr_fifo.sv
// tb_rram_instr_fifo: directed self-checking bench for rram_instr_fifo.
module tb_rram_instr_fifo;
    localparam int unsigned WIDTH = 20;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] w;

    rram_instr_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rram_instr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive the requests, take the edge, release the requests.
    task automatic tick(input logic do_push, input logic do_pop, input logic [WIDTH-1:0] d);
        bus.push_n = !do_push;
        bus.pop_n  = !do_pop;
        bus.din    = d;
        @(posedge clk);
        #1;
        bus.push_n = 1'b1;
        bus.pop_n  = 1'b1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n      = 1'b0;
        bus.push_n = 1'b1;
        bus.pop_n  = 1'b1;
        bus.din    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_full",  32'(bus.full), 32'd0);
        check("rst_af",    32'(bus.almost_full), 32'd0);
        check("rst_dout",  32'(bus.dout), 32'd0);

        // Fill and drain in order
        tick(1'b1, 1'b0, 20'h4_0000);
        check("fd_empty1", 32'(bus.empty), 32'd0);
        check("fd_dout1",  32'(bus.dout), 32'h4_0000);
        tick(1'b1, 1'b0, 20'h4_440A);
        tick(1'b1, 1'b0, 20'h1_2345);
        check("fd_count3", 32'(bus.count), 32'd3);
        check("fd_pop0",   32'(bus.dout), 32'h4_0000);
        tick(1'b0, 1'b1, '0);
        check("fd_pop1",   32'(bus.dout), 32'h4_440A);
        tick(1'b0, 1'b1, '0);
        check("fd_pop2",   32'(bus.dout), 32'h1_2345);
        tick(1'b0, 1'b1, '0);
        check("fd_empty",  32'(bus.empty), 32'd1);
        check("fd_count0", 32'(bus.count), 32'd0);

        // Empty boundary: pop on empty, then push+pop on empty
        tick(1'b0, 1'b1, '0);
        check("eb_count",  32'(bus.count), 32'd0);
        check("eb_empty",  32'(bus.empty), 32'd1);
`ifdef RRAM_INSTR_FIFO_ERR_EN
        check("eb_underflow", 32'(bus.underflow), 32'd1);
        check("eb_overflow0", 32'(bus.overflow), 32'd0);
`endif
        tick(1'b1, 1'b1, 20'h0_ABCD);
        check("eb_pp_count", 32'(bus.count), 32'd1);
        check("eb_pp_dout",  32'(bus.dout), 32'h0_ABCD);
        tick(1'b0, 1'b1, '0);
        check("eb_drain", 32'(bus.empty), 32'd1);

        // Full boundary
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 20'h1_0000 + 20'(i));
            if (i == 10) check("fb_af_at11", 32'(bus.almost_full), 32'd0);
            if (i == 11) check("fb_af_at12", 32'(bus.almost_full), 32'd1);
            if (i == 14) check("fb_full_at15", 32'(bus.full), 32'd0);
        end
        check("fb_full",  32'(bus.full), 32'd1);
        check("fb_count", 32'(bus.count), 32'd16);
        tick(1'b1, 1'b0, 20'hF_FFFF);
        check("fb_drop_count", 32'(bus.count), 32'd16);
        check("fb_drop_head",  32'(bus.dout), 32'h1_0000);
`ifdef RRAM_INSTR_FIFO_ERR_EN
        check("fb_overflow", 32'(bus.overflow), 32'd1);
`endif
        tick(1'b1, 1'b1, 20'h2_2222);
        check("fb_pp_count", 32'(bus.count), 32'd16);
        check("fb_pp_full",  32'(bus.full), 32'd1);
        for (int i = 1; i < 16; i++) begin
            check("fb_drain", 32'(bus.dout), 32'h1_0000 + 32'(i));
            tick(1'b0, 1'b1, '0);
        end
        check("fb_last", 32'(bus.dout), 32'h2_2222);
        tick(1'b0, 1'b1, '0);
        check("fb_empty", 32'(bus.empty), 32'd1);

        // Wrap-around at constant occupancy 3
        q.delete();
        for (int i = 0; i < 3; i++) begin
            w = 20'h3_0000 + 20'(i);
            q.push_back(w);
            tick(1'b1, 1'b0, w);
        end
        for (int i = 3; i < 43; i++) begin
            w = 20'h3_0000 + 20'(i);
            check("wr_dout", 32'(bus.dout), 32'(q[0]));
            void'(q.pop_front());
            q.push_back(w);
            tick(1'b1, 1'b1, w);
            check("wr_count", 32'(bus.count), 32'd3);
        end
        while (q.size() != 0) begin
            check("wr_tail", 32'(bus.dout), 32'(q[0]));
            void'(q.pop_front());
            tick(1'b0, 1'b1, '0);
        end
        check("wr_empty", 32'(bus.empty), 32'd1);

        // Back-to-back streaming with one-cycle head start
        tick(1'b1, 1'b0, 20'h5_0000);
        q.push_back(20'h5_0000);
        for (int i = 1; i <= 20; i++) begin
            w = 20'h5_0000 + 20'(i);
            check("st_dout", 32'(bus.dout), 32'(q[0]));
            void'(q.pop_front());
            q.push_back(w);
            tick(1'b1, 1'b1, w);
            check("st_count", 32'(bus.count), 32'd1);
            check("st_full",  32'(bus.full), 32'd0);
        end
        q.delete();

        // Mid-stream reset with 5 entries held (1 left from streaming + 4)
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 20'h6_0000 + 20'(i));
        check("mr_count5", 32'(bus.count), 32'd5);
        rst_n = 1'b0;
        #1;
        check("mr_empty", 32'(bus.empty), 32'd1);
        check("mr_count", 32'(bus.count), 32'd0);
        check("mr_dout",  32'(bus.dout), 32'd0);
        check("mr_full",  32'(bus.full), 32'd0);
`ifdef RRAM_INSTR_FIFO_ERR_EN
        check("mr_overflow",  32'(bus.overflow), 32'd0);
        check("mr_underflow", 32'(bus.underflow), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b1, '0);
        check("mr_pop_empty", 32'(bus.empty), 32'd1);
        check("mr_pop_count", 32'(bus.count), 32'd0);
        check("mr_pop_dout",  32'(bus.dout), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
